// File: rtl/rv32_decode_pkg.sv
// Shared decode definitions for the RV32IM ID stage: opcodes, immediate-type
// encodings, controller states and the decoded control bundle.
package rv32_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_J = 3'b010,
        IMM_U = 3'b011,
        IMM_B = 3'b100
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_FULL   = 2'b01,
        ST_HAZARD = 2'b10
    } id_state_e;

    typedef struct packed {
        imm_type_e imm_type;
        logic      imm_en;
        logic      reg_write_en;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      jump;
        logic      mdu_sel;
        logic      rs1_used;
        logic      rs2_used;
        logic      illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/rv32_opcode_decoder.sv
// Combinational RV32IM opcode decoder: instruction fields -> control bundle.
// Illegal-instruction detection is built only with ID_ILLEGAL_TRAP_EN defined.
module rv32_opcode_decoder
    import rv32_decode_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [6:0] i_funct7,
    input  logic [4:0] i_rd,
    output dec_ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl          = '0;
        o_ctrl.imm_type = IMM_I;
        case (i_opcode)
            OPC_LUI, OPC_AUIPC: begin
                o_ctrl.imm_type     = IMM_U;
                o_ctrl.imm_en       = 1'b1;
                o_ctrl.reg_write_en = 1'b1;
            end
            OPC_JAL: begin
                o_ctrl.imm_type     = IMM_J;
                o_ctrl.imm_en       = 1'b1;
                o_ctrl.reg_write_en = 1'b1;
                o_ctrl.jump         = 1'b1;
            end
            OPC_JALR: begin
                o_ctrl.imm_en       = 1'b1;
                o_ctrl.reg_write_en = 1'b1;
                o_ctrl.jump         = 1'b1;
                o_ctrl.rs1_used     = 1'b1;
            end
            OPC_BRANCH: begin
                o_ctrl.imm_type = IMM_B;
                o_ctrl.branch   = 1'b1;
                o_ctrl.rs1_used = 1'b1;
                o_ctrl.rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                o_ctrl.imm_en       = 1'b1;
                o_ctrl.reg_write_en = 1'b1;
                o_ctrl.mem_read     = 1'b1;
                o_ctrl.rs1_used     = 1'b1;
            end
            OPC_STORE: begin
                o_ctrl.imm_type  = IMM_S;
                o_ctrl.imm_en    = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.rs1_used  = 1'b1;
                o_ctrl.rs2_used  = 1'b1;
            end
            OPC_OPIMM: begin
                o_ctrl.imm_en       = 1'b1;
                o_ctrl.reg_write_en = 1'b1;
                o_ctrl.rs1_used     = 1'b1;
            end
            OPC_OP: begin
                o_ctrl.reg_write_en = 1'b1;
                o_ctrl.rs1_used     = 1'b1;
                o_ctrl.rs2_used     = 1'b1;
                o_ctrl.mdu_sel      = (i_funct7 == F7_MDU);
`ifdef ID_ILLEGAL_TRAP_EN
                o_ctrl.illegal      = !((i_funct7 == F7_BASE) || (i_funct7 == F7_ALT) ||
                                        (i_funct7 == F7_MDU));
`endif
            end
            OPC_FENCE, OPC_SYSTEM: begin
            end
            default: begin
`ifdef ID_ILLEGAL_TRAP_EN
                o_ctrl.illegal = 1'b1;
`endif
            end
        endcase

        if (i_rd == 5'd0) o_ctrl.reg_write_en = 1'b0;

`ifdef ID_ILLEGAL_TRAP_EN
        // A trapping instruction must not leave any architectural side effect.
        if (o_ctrl.illegal) begin
            o_ctrl.reg_write_en = 1'b0;
            o_ctrl.mem_read     = 1'b0;
            o_ctrl.mem_write    = 1'b0;
            o_ctrl.branch       = 1'b0;
            o_ctrl.jump         = 1'b0;
            o_ctrl.mdu_sel      = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/id_stage_controller.sv
// RV32IM decode-stage controller: IF/ID register, load-use hazard bubble,
// fetch/execute handshake, flush and stall counter. Option: ID_ILLEGAL_TRAP_EN.
module id_stage_controller
    import rv32_decode_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IF_VALID,
    input  logic [31:0]            IF_INSTRUCTION,
    input  logic [XLEN-1:0]        IF_PC,
    output logic                   ID_READY,
    input  logic                   FLUSH,
    input  logic                   EX_READY,
    input  logic                   EX_MEM_READ,
    input  logic [4:0]             EX_RD,
    output logic                   ID_VALID,
    output logic [31:0]            ID_INSTRUCTION,
    output logic [XLEN-1:0]        ID_PC,
    output logic [2:0]             IMMEDIATE_TYPE,
    output logic                   IMM_EN,
    output logic [4:0]             RS1,
    output logic [4:0]             RS2,
    output logic [4:0]             RD,
    output logic                   REG_WRITE_EN,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic                   BRANCH,
    output logic                   JUMP,
    output logic                   MDU_SEL,
    output logic [STALL_CNT_W-1:0] STALL_COUNT,
    output logic                   ILLEGAL
);

    id_state_e              r_state, w_state_nxt;
    logic [31:0]            r_instr;
    logic [XLEN-1:0]        r_pc;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    dec_ctrl_t w_dec;
    logic      w_entry, w_hazard, w_issue, w_load, w_clear;

    rv32_opcode_decoder u_dec (
        .i_opcode (r_instr[6:0]),
        .i_funct7 (r_instr[31:25]),
        .i_rd     (r_instr[11:7]),
        .o_ctrl   (w_dec)
    );

    assign RS1 = r_instr[19:15];
    assign RS2 = r_instr[24:20];
    assign RD  = r_instr[11:7];

    assign w_entry  = (r_state != ST_EMPTY);
    assign w_hazard = w_entry && EX_MEM_READ && (EX_RD != 5'd0) &&
                      ((w_dec.rs1_used && (RS1 == EX_RD)) ||
                       (w_dec.rs2_used && (RS2 == EX_RD)));
    assign w_issue  = (r_state == ST_FULL) && !w_hazard && EX_READY;

    assign ID_VALID = (r_state == ST_FULL) && !w_hazard;
    assign ID_READY = (r_state == ST_EMPTY) || w_issue;

    // Control flags are masked while empty so a stale register never looks live.
    assign IMMEDIATE_TYPE = w_entry ? w_dec.imm_type : IMM_I;
    assign IMM_EN         = w_entry && w_dec.imm_en;
    assign REG_WRITE_EN   = w_entry && w_dec.reg_write_en;
    assign MEM_READ       = w_entry && w_dec.mem_read;
    assign MEM_WRITE      = w_entry && w_dec.mem_write;
    assign BRANCH         = w_entry && w_dec.branch;
    assign JUMP           = w_entry && w_dec.jump;
    assign MDU_SEL        = w_entry && w_dec.mdu_sel;
    assign ILLEGAL        = w_entry && w_dec.illegal;

    assign ID_INSTRUCTION = r_instr;
    assign ID_PC          = r_pc;
    assign STALL_COUNT    = r_stall_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        if (FLUSH) begin
            w_state_nxt = ST_EMPTY;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (IF_VALID) begin
                        w_state_nxt = ST_FULL;
                        w_load      = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_hazard) begin
                        w_state_nxt = ST_HAZARD;
                    end else if (EX_READY) begin
                        w_state_nxt = IF_VALID ? ST_FULL : ST_EMPTY;
                        w_load      = IF_VALID;
                    end
                end
                ST_HAZARD: w_state_nxt = ST_FULL;
                default:   w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_EMPTY;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_instr <= NOP_INSTR;
                r_pc    <= '0;
            end else if (w_load) begin
                r_instr <= IF_INSTRUCTION;
                r_pc    <= IF_PC;
            end
        end
    end

    // Counts every occupied cycle that does not hand an instruction to EX.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_stall_cnt <= '0;
        end else if (w_entry && !w_issue && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage_controller.sv
// Directed scoreboard bench for id_stage_controller: expected issues are queued
// when fetch presents them and checked as EX takes them.
module tb_id_stage_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IF_VALID = 1'b0;
    logic [31:0] IF_INSTRUCTION = 32'h0;
    logic [31:0] IF_PC = 32'h0;
    logic        ID_READY;
    logic        FLUSH = 1'b0;
    logic        EX_READY = 1'b1;
    logic        EX_MEM_READ = 1'b0;
    logic [4:0]  EX_RD = 5'd0;
    logic        ID_VALID;
    logic [31:0] ID_INSTRUCTION;
    logic [31:0] ID_PC;
    logic [2:0]  IMMEDIATE_TYPE;
    logic        IMM_EN;
    logic [4:0]  RS1, RS2, RD;
    logic        REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP, MDU_SEL;
    logic [15:0] STALL_COUNT;
    logic        ILLEGAL;

    id_stage_controller #(.XLEN(32), .STALL_CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .IF_VALID(IF_VALID), .IF_INSTRUCTION(IF_INSTRUCTION),
        .IF_PC(IF_PC), .ID_READY(ID_READY), .FLUSH(FLUSH), .EX_READY(EX_READY),
        .EX_MEM_READ(EX_MEM_READ), .EX_RD(EX_RD), .ID_VALID(ID_VALID),
        .ID_INSTRUCTION(ID_INSTRUCTION), .ID_PC(ID_PC), .IMMEDIATE_TYPE(IMMEDIATE_TYPE),
        .IMM_EN(IMM_EN), .RS1(RS1), .RS2(RS2), .RD(RD), .REG_WRITE_EN(REG_WRITE_EN),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .BRANCH(BRANCH), .JUMP(JUMP),
        .MDU_SEL(MDU_SEL), .STALL_COUNT(STALL_COUNT), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // flags: {IMM_EN, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP, MDU_SEL}
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm;
        logic [6:0]  flg;
        logic [14:0] regs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_sc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents an instruction to fetch and records how it must look at issue.
    task automatic present(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [2:0] imm, input logic [6:0] flg, input bit expect_issue);
        exp_t e;
        IF_VALID       = 1'b1;
        IF_INSTRUCTION = ins;
        IF_PC          = pc;
        e.instr = ins;
        e.pc    = pc;
        e.imm   = imm;
        e.flg   = flg;
        e.regs  = {ins[19:15], ins[24:20], ins[11:7]};
        if (expect_issue) sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge CLK);
        if (ID_VALID && EX_READY) begin
            if (sb.size() == 0) begin
                chk("spurious_issue", 64'(ID_VALID), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("issue_instr", 64'(ID_INSTRUCTION), 64'(e.instr));
                chk("issue_pc", 64'(ID_PC), 64'(e.pc));
                chk("issue_imm_type", 64'(IMMEDIATE_TYPE), 64'(e.imm));
                chk("issue_flags", 64'({IMM_EN, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP, MDU_SEL}),
                    64'(e.flg));
                chk("issue_regs", 64'({RS1, RS2, RD}), 64'(e.regs));
                chk("issue_illegal", 64'(ILLEGAL), 64'd0);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b0;
        @(posedge CLK); #1;

        chk("rst_id_valid", 64'(ID_VALID), 64'd0);
        chk("rst_id_ready", 64'(ID_READY), 64'd1);
        chk("rst_stall", 64'(STALL_COUNT), 64'd0);
        chk("rst_instr", 64'(ID_INSTRUCTION), 64'h13);
        chk("rst_pc", 64'(ID_PC), 64'd0);
        chk("rst_imm_type", 64'(IMMEDIATE_TYPE), 64'd0);
        chk("rst_flags", 64'({IMM_EN, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP, MDU_SEL, ILLEGAL}), 64'd0);

        // Back-to-back stream: ADDI, SW, LW, LUI, ADDI x0 (write suppressed).
        present(32'h00510093, 32'h100, 3'b000, 7'b1100000, 1'b1); tick();
        present(32'h00512423, 32'h104, 3'b001, 7'b1001000, 1'b1); tick();
        chk("stream_ready", 64'(ID_READY), 64'd1);
        present(32'h00812303, 32'h108, 3'b000, 7'b1110000, 1'b1); tick();
        present(32'h123452B7, 32'h10C, 3'b011, 7'b1100000, 1'b1); tick();
        present(32'h00000013, 32'h110, 3'b000, 7'b1000000, 1'b1); tick();
        IF_VALID = 1'b0;
        tick();
        tick();
        chk("stream_drained", 64'(sb.size()), 64'd0);
        chk("stream_no_stall", 64'(STALL_COUNT), 64'(exp_sc));
        chk("empty_valid", 64'(ID_VALID), 64'd0);

        // Load in EX writing x0 is never a hazard.
        EX_MEM_READ = 1'b1; EX_RD = 5'd0;
        present(32'h004081B3, 32'h200, 3'b000, 7'b0100000, 1'b1); tick();
        IF_VALID = 1'b0;
        tick();
        chk("x0_no_stall", 64'(STALL_COUNT), 64'(exp_sc));

        // Load-use: ADD x3,x1,x4 behind a load to x1.
        EX_RD = 5'd1;
        present(32'h004081B3, 32'h204, 3'b000, 7'b0100000, 1'b1); tick();
        IF_VALID = 1'b0;
        chk("haz_valid", 64'(ID_VALID), 64'd0);
        chk("haz_ready", 64'(ID_READY), 64'd0);
        chk("haz_stall0", 64'(STALL_COUNT), 64'(exp_sc));
        tick();
        EX_MEM_READ = 1'b0;
        exp_sc += 1;
        chk("haz_bubble_valid", 64'(ID_VALID), 64'd0);
        chk("haz_stall1", 64'(STALL_COUNT), 64'(exp_sc));
        tick();
        exp_sc += 1;
        chk("haz_resume_valid", 64'(ID_VALID), 64'd1);
        tick();
        chk("haz_stall_final", 64'(STALL_COUNT), 64'(exp_sc));
        chk("haz_drained", 64'(sb.size()), 64'd0);

        // JAL then BEQ.
        present(32'h008000EF, 32'h300, 3'b010, 7'b1100010, 1'b1); tick();
        present(32'h00208463, 32'h304, 3'b100, 7'b0000100, 1'b1); tick();
        IF_VALID = 1'b0;
        tick();
        tick();
        chk("ctl_drained", 64'(sb.size()), 64'd0);

        // Flush while FULL with a new instruction arriving: neither may issue.
        EX_READY = 1'b0;
        present(32'h00510093, 32'h400, 3'b000, 7'b1100000, 1'b0); tick();
        FLUSH = 1'b1;
        present(32'h00512423, 32'h404, 3'b001, 7'b1001000, 1'b0); tick();
        exp_sc += 1;
        FLUSH = 1'b0; IF_VALID = 1'b0; EX_READY = 1'b1;
        chk("flush_valid", 64'(ID_VALID), 64'd0);
        chk("flush_ready", 64'(ID_READY), 64'd1);
        chk("flush_instr", 64'(ID_INSTRUCTION), 64'h13);
        chk("flush_stall", 64'(STALL_COUNT), 64'(exp_sc));
        tick();
        tick();

        // MUL held by a busy MDU for three cycles.
        EX_READY = 1'b0;
        present(32'h024081B3, 32'h500, 3'b000, 7'b0100001, 1'b1); tick();
        IF_VALID = 1'b0;
        chk("mul_mdu_sel", 64'(MDU_SEL), 64'd1);
        chk("mul_ready_busy", 64'(ID_READY), 64'd0);
        tick(); tick(); tick();
        exp_sc += 3;
        chk("mul_stall", 64'(STALL_COUNT), 64'(exp_sc));
        chk("mul_held", 64'(ID_INSTRUCTION), 64'h024081B3);
        EX_READY = 1'b1;
        tick();
        chk("mul_drained", 64'(sb.size()), 64'd0);
        chk("mul_stall_after", 64'(STALL_COUNT), 64'(exp_sc));

        // Asynchronous reset while FULL holding an ADDI.
        EX_READY = 1'b0;
        present(32'h00510093, 32'h600, 3'b000, 7'b1100000, 1'b0); tick();
        IF_VALID = 1'b0;
        tick();
        #2 RESET = 1'b1;
        #1;
        chk("arst_valid_now", 64'(ID_VALID), 64'd0);
        tick();
        RESET = 1'b0; EX_READY = 1'b1;
        chk("arst_valid", 64'(ID_VALID), 64'd0);
        chk("arst_ready", 64'(ID_READY), 64'd1);
        chk("arst_stall", 64'(STALL_COUNT), 64'd0);
        chk("arst_instr", 64'(ID_INSTRUCTION), 64'h13);
        tick();
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
